// File: rtl/iscas_bist_harness_if.sv
// rtl/iscas_bist_harness_if.sv - boundary bus between the BIST harness and its pad/core side
//   bist_en, start : run control from the pad side
//   pi             : functional primary inputs
//   core_in        : registered inputs driving the external core
//   core_out       : combinational core outputs
//   po             : registered core outputs
//   busy, done     : run status
//   signature      : MISR contents
//   vec_count      : vectors applied in the current or last run
interface iscas_bist_harness_if #(
    parameter int N_IN   = 36,
    parameter int N_OUT  = 7,
    parameter int MISR_W = 16,
    parameter int VCNT_W = 11
);
    logic              bist_en;
    logic              start;
    logic [N_IN-1:0]   pi;
    logic [N_IN-1:0]   core_in;
    logic [N_OUT-1:0]  core_out;
    logic [N_OUT-1:0]  po;
    logic              busy;
    logic              done;
    logic [MISR_W-1:0] signature;
    logic [VCNT_W-1:0] vec_count;

    // master: pads plus the external core; slave: the harness
    modport master (
        output bist_en, start, pi, core_out,
        input  core_in, po, busy, done, signature, vec_count
    );
    modport slave (
        input  bist_en, start, pi, core_out,
        output core_in, po, busy, done, signature, vec_count
    );
endinterface

// File: rtl/iscas_bist_harness.sv
// rtl/iscas_bist_harness.sv - clocked boundary and LFSR/MISR self-test around a combinational ISCAS core
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything
//   bus : iscas_bist_harness_if slave (pi/core_in/core_out/po banks, bist_en/start, busy/done/signature/vec_count)
module iscas_bist_harness #(
    parameter int                N_IN      = 36,
    parameter int                N_OUT     = 7,
    parameter int                MISR_W    = 16,
    parameter int                NUM_VEC   = 1024,
    parameter logic [N_IN-1:0]   SEED      = N_IN'(1),
    parameter logic [N_IN-1:0]   LFSR_TAPS = N_IN'(36'h800000800),
    parameter logic [MISR_W-1:0] MISR_TAPS = MISR_W'(16'hB400),
    parameter int                VCNT_W    = $clog2(NUM_VEC + 1)
) (
    input logic                 clk,
    input logic                 rst,
    iscas_bist_harness_if.slave bus
);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0]   SEED_EFF = (SEED == '0) ? N_IN'(1) : SEED;
    localparam logic [VCNT_W-1:0] VLAST    = VCNT_W'(NUM_VEC - 1);
    localparam logic [VCNT_W-1:0] VMAX     = VCNT_W'(NUM_VEC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   core_in_q;
    logic [N_OUT-1:0]  po_q;
    logic [N_IN-1:0]   lfsr;
    logic [MISR_W-1:0] misr;
    logic [VCNT_W-1:0] vcnt;
    logic              busy_q;
    logic              done_q;
    logic              v1;          // core_in holds a BIST vector
    logic              v2;          // po holds the response to a BIST vector
    logic              flush_last;  // second FLUSH edge

    logic [N_IN-1:0]   lfsr_next;
    logic [MISR_W-1:0] misr_next;

    assign lfsr_next = {lfsr[N_IN-2:0], ^(lfsr & LFSR_TAPS)};
    assign misr_next = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ MISR_W'(po_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            core_in_q  <= '0;
            po_q       <= '0;
            lfsr       <= SEED_EFF;
            misr       <= '0;
            vcnt       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            flush_last <= 1'b0;
        end else begin
            po_q      <= bus.core_out;
            core_in_q <= bus.pi;
            v1        <= 1'b0;
            v2        <= v1;
            if (v2) begin
                misr <= misr_next;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start && bus.bist_en) begin
                        state  <= S_RUN;
                        lfsr   <= SEED_EFF;
                        misr   <= '0;
                        vcnt   <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    core_in_q <= lfsr;
                    lfsr      <= lfsr_next;
                    v1        <= 1'b1;
                    if (vcnt != VMAX) begin
                        vcnt <= vcnt + VCNT_W'(1);
                    end
                    if (vcnt == VLAST) begin
                        state      <= S_FLUSH;
                        flush_last <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Two edges: the last vector's response reaches po, then the MISR.
                    if (flush_last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        flush_last <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.start && bus.bist_en) begin
                        state  <= S_RUN;
                        lfsr   <= SEED_EFF;
                        misr   <= '0;
                        vcnt   <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end else if (!bus.bist_en) begin
                        state  <= S_IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_in   = core_in_q;
    assign bus.po        = po_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr;
    assign bus.vec_count = vcnt;
endmodule

// File: tb/tb_iscas_bist_harness.sv
// tb/tb_iscas_bist_harness.sv - self-checking bench for iscas_bist_harness
module tb_iscas_bist_harness;
    localparam int AV = 1024;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    logic chk_on = 1'b0;
    logic rand_pi = 1'b0;
    logic fault_en = 1'b0;
    logic fault_a = 1'b0;

    iscas_bist_harness_if #(.N_IN(36), .N_OUT(7), .MISR_W(16), .VCNT_W(11)) a_if ();
    iscas_bist_harness_if #(.N_IN(8),  .N_OUT(7), .MISR_W(16), .VCNT_W(3))  b_if ();
    iscas_bist_harness_if #(.N_IN(8),  .N_OUT(7), .MISR_W(16), .VCNT_W(9))  c_if ();

    // External cores: identity (with optional single-vector fault), add-3, identity.
    assign a_if.core_out = a_if.core_in[6:0] ^ {6'b0, fault_a};
    assign b_if.core_out = b_if.core_in[6:0] + 7'd3;
    assign c_if.core_out = c_if.core_in[6:0];

    iscas_bist_harness dut_a (.clk(clk), .rst(rst), .bus(a_if));

    iscas_bist_harness #(
        .N_IN(8), .N_OUT(7), .MISR_W(16), .NUM_VEC(4),
        .SEED(8'h01), .LFSR_TAPS(8'hB8), .MISR_TAPS(16'hB400)
    ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    iscas_bist_harness #(
        .N_IN(8), .N_OUT(7), .MISR_W(16), .NUM_VEC(300),
        .SEED(8'h00), .LFSR_TAPS(8'hB8), .MISR_TAPS(16'hB400)
    ) dut_c (.clk(clk), .rst(rst), .bus(c_if));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
        n_chk++;
        if (act === bad) begin
            n_err++;
            $display("FAIL %s: got %0h, must differ from %0h", name, act, bad);
        end
    endtask

    function automatic logic [35:0] lfsr_next(input logic [35:0] v);
        return {v[34:0], ^(v & 36'h800000800)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [6:0] r);
        return {m[14:0], ^(m & 16'hB400)} ^ {9'b0, r};
    endfunction

    // Reference model for dut_a: the run is described by the number of edges
    // since the accepted start; vectors come from a precomputed list and the
    // signature is folded from the recorded responses once the run ends.
    logic [35:0] vec_a [1:AV];
    logic [6:0]  m_resp [1:AV];
    logic [35:0] m_core_in;
    logic [6:0]  m_po;
    logic        m_busy, m_done, m_running;
    int          m_vcnt, m_phase;
    logic [15:0] m_sig;

    always @(posedge clk) begin
        logic [35:0] ci_n;
        logic [6:0]  po_n;
        po_n = m_core_in[6:0] ^ {6'b0, fault_a};
        if (rst) begin
            m_core_in = '0;
            m_po      = '0;
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_running = 1'b0;
            m_vcnt    = 0;
            m_phase   = 0;
            m_sig     = '0;
        end else begin
            ci_n = a_if.pi;
            if (m_running) begin
                m_phase++;
                if (m_phase <= AV) begin
                    ci_n   = vec_a[m_phase];
                    m_vcnt = m_phase;
                end
                if (m_phase >= 2 && m_phase <= AV + 1) m_resp[m_phase-1] = po_n;
                if (m_phase == AV + 2) begin
                    m_running = 1'b0;
                    m_busy    = 1'b0;
                    m_done    = 1'b1;
                    m_sig     = '0;
                    for (int k = 1; k <= AV; k++) m_sig = misr_step(m_sig, m_resp[k]);
                end
            end else if (a_if.start && a_if.bist_en) begin
                m_running = 1'b1;
                m_phase   = 0;
                m_vcnt    = 0;
                m_busy    = 1'b1;
                m_done    = 1'b0;
            end else if (m_done && !a_if.bist_en) begin
                m_done = 1'b0;
            end
            m_core_in = ci_n;
            m_po      = po_n;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_core_in",   64'(a_if.core_in),   64'(m_core_in));
            check("a_po",        64'(a_if.po),        64'(m_po));
            check("a_busy",      64'(a_if.busy),      64'(m_busy));
            check("a_done",      64'(a_if.done),      64'(m_done));
            check("a_vec_count", 64'(a_if.vec_count), 64'(m_vcnt));
            if (m_done) check("a_signature", 64'(a_if.signature), 64'(m_sig));
        end
        fault_a = fault_en && m_running && (m_phase == 17);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rand_pi) a_if.pi = 36'({$urandom(), $urandom()});
        end
    endtask

    task automatic start_a();
        a_if.bist_en = 1'b1;
        a_if.start   = 1'b1;
        step(1);
        a_if.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (a_if.done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("a_done_timeout", 64'(a_if.done), 64'd1);
    endtask

    logic [15:0] clean_sig;
    logic [7:0]  exp_b [4];
    int          zeros;
    int          nb;

    initial begin
        rst = 1'b1;
        a_if.bist_en = 1'b0; a_if.start = 1'b0; a_if.pi = '0;
        b_if.bist_en = 1'b0; b_if.start = 1'b0; b_if.pi = '0;
        c_if.bist_en = 1'b0; c_if.start = 1'b0; c_if.pi = '0;

        vec_a[1] = 36'd1;
        for (int k = 2; k <= AV; k++) vec_a[k] = lfsr_next(vec_a[k-1]);
        check("model_vec1",  64'(vec_a[1]),  64'h1);
        check("model_vec13", 64'(vec_a[13]), 64'h1001);

        step(2);
        chk_on = 1'b1;
        check("rst_core_in",   64'(a_if.core_in),   64'h0);
        check("rst_po",        64'(a_if.po),        64'h0);
        check("rst_busy",      64'(a_if.busy),      64'h0);
        check("rst_done",      64'(a_if.done),      64'h0);
        check("rst_vec_count", 64'(a_if.vec_count), 64'h0);
        check("rst_b_core_in", 64'(b_if.core_in),   64'h0);
        rst = 1'b0;

        // Pass-through latency: pi -> po in two edges.
        a_if.pi = 36'h5A;
        step(1);
        check("pt_core_in", 64'(a_if.core_in), 64'h5A);
        step(1);
        check("pt_po", 64'(a_if.po), 64'h5A);
        rand_pi = 1'b1;
        step(20);

        // Clean BIST run on the default configuration.
        start_a();
        check("a_busy_E0", 64'(a_if.busy), 64'h1);
        step(1); check("a_vec_E1", 64'(a_if.core_in), 64'h1);
        step(1); check("a_vec_E2", 64'(a_if.core_in), 64'h2);
        step(1); check("a_vec_E3", 64'(a_if.core_in), 64'h4);
        wait_done_a(1100);
        clean_sig = m_sig;
        check("a_vcnt_done", 64'(a_if.vec_count), 64'd1024);
        step(3);

        // Restart from DONE with a stray start at E2 of the run.
        start_a();
        step(1);
        a_if.start = 1'b1;
        step(1);
        a_if.start = 1'b0;
        wait_done_a(1100);
        check("a_repeat_sig",  64'(a_if.signature), 64'(clean_sig));
        check("a_repeat_vcnt", 64'(a_if.vec_count), 64'd1024);

        // Single-vector fault must change the signature.
        fault_en = 1'b1;
        start_a();
        wait_done_a(1100);
        check_ne("a_fault_sig", 64'(a_if.signature), 64'(clean_sig));
        fault_en = 1'b0;

        a_if.bist_en = 1'b0;
        step(10);

        // Reset at E3 aborts the run.
        start_a();
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort_core_in", 64'(a_if.core_in),   64'h0);
        check("abort_po",      64'(a_if.po),        64'h0);
        check("abort_busy",    64'(a_if.busy),      64'h0);
        check("abort_done",    64'(a_if.done),      64'h0);
        check("abort_vcnt",    64'(a_if.vec_count), 64'h0);
        step(6);
        start_a();
        wait_done_a(1100);
        check("abort_rerun_sig", 64'(a_if.signature), 64'(clean_sig));
        a_if.bist_en = 1'b0;

        // Short run timing on the 8-bit, 4-vector instance.
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h04; exp_b[3] = 8'h08;
        b_if.bist_en = 1'b1;
        b_if.start   = 1'b1;
        step(1);
        b_if.start = 1'b0;
        check("b_busy_E0", 64'(b_if.busy),      64'h1);
        check("b_vcnt_E0", 64'(b_if.vec_count), 64'h0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("b_vec_E%0d", k + 1), 64'(b_if.core_in), 64'(exp_b[k]));
        end
        check("b_vcnt_E4", 64'(b_if.vec_count), 64'd4);
        check("b_busy_E4", 64'(b_if.busy),      64'h1);
        step(1);
        check("b_busy_E5", 64'(b_if.busy), 64'h1);
        check("b_done_E5", 64'(b_if.done), 64'h0);
        step(1);
        check("b_busy_E6", 64'(b_if.busy),      64'h0);
        check("b_done_E6", 64'(b_if.done),      64'h1);
        check("b_sig",     64'(b_if.signature), 64'h0031);
        check("b_vcnt_E6", 64'(b_if.vec_count), 64'd4);

        // Zero seed: first vector is 1 and the LFSR never reaches zero.
        c_if.bist_en = 1'b1;
        c_if.start   = 1'b1;
        step(1);
        c_if.start = 1'b0;
        step(1);
        check("c_first_vec", 64'(c_if.core_in), 64'h1);
        zeros = 0;
        for (int k = 2; k <= 300; k++) begin
            step(1);
            if (c_if.core_in == 8'h00) zeros++;
        end
        check("c_zero_vectors", 64'(zeros), 64'd0);
        nb = 0;
        while (c_if.done !== 1'b1 && nb < 10) begin
            step(1);
            nb++;
        end
        check("c_done",      64'(c_if.done),      64'h1);
        check("c_vec_count", 64'(c_if.vec_count), 64'd300);

        step(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
